io_request_arbiter: RTL and testbench

// Arbitrates non-cached I/O requests (ioreq_packet_t) from NUM_REQUESTERS cores onto one
// io_bus_interface master and returns each result as an iorsp_packet_t tagged with core/thread.

---
 rtl/io_request_arbiter_pkg.sv | 23 ++
 rtl/io_bus_interface.sv | 15 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/io_request_arbiter.sv | 100 ++++++++++
 tb/tb_io_request_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_request_arbiter_pkg.sv
// Shared I/O request/response types used by the core-side queues and the I/O arbiter.
package io_request_arbiter_pkg;

   localparam int unsigned NUM_CORES = 4;

   typedef logic [3:0]  core_id_t;
   typedef logic [1:0]  local_thread_idx_t;
   typedef logic [31:0] scalar_t;

   typedef struct packed {
      logic              store;
      local_thread_idx_t thread_idx;
      scalar_t           address;
      scalar_t           value;
   } ioreq_packet_t;

   typedef struct packed {
      core_id_t          core;
      local_thread_idx_t thread_idx;
      scalar_t           read_value;
   } iorsp_packet_t;

endpackage

// File: rtl/io_bus_interface.sv
// Simple peripheral register bus: one write or read per cycle, read data one cycle later.
interface io_bus_interface;
   import io_request_arbiter_pkg::*;

   logic    write_en;
   logic    read_en;
   scalar_t address;
   scalar_t write_data;
   scalar_t read_data;

   modport master(output write_en, output read_en, output address, output write_data,
                  input read_data);
   modport slave(input write_en, input read_en, input address, input write_data,
                 output read_data);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer.
module rr_arbiter #(
   parameter int unsigned NUM_REQUESTERS = 4
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQUESTERS-1:0] request,
   input  logic                      update_lru,
   output logic [NUM_REQUESTERS-1:0] grant
);
   localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      logic [PTR_W-1:0] idx;
      logic             found;
      grant = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         idx = PTR_W'((32'(ptr_q) + i) % NUM_REQUESTERS);
         if (!found && request[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_d      = PTR_W'((32'(idx) + 1) % NUM_REQUESTERS);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q <= '0;
      end else if (update_lru) begin
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: rtl/io_request_arbiter.sv
// Arbitrates per-core I/O requests onto one bus master; responses return 3 cycles after
// grant, in grant order, tagged with the granted core and thread.
module io_request_arbiter
   import io_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQUESTERS = NUM_CORES
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQUESTERS-1:0] ior_request_valid,
   input  ioreq_packet_t             ior_request [NUM_REQUESTERS],
   output logic [NUM_REQUESTERS-1:0] ia_ready,
   output logic                      ia_response_valid,
   output iorsp_packet_t             ia_response,
   io_bus_interface.master           io_bus
);
   typedef struct packed {
      logic              valid;
      logic              store;
      core_id_t          core;
      local_thread_idx_t thread_idx;
   } io_pipe_tag_t;

   logic [NUM_REQUESTERS-1:0] grant;
   logic                      has_grant;
   core_id_t                  grant_core;
   ioreq_packet_t             grant_req;

   logic         write_en_q;
   logic         read_en_q;
   scalar_t      address_q;
   scalar_t      write_data_q;
   io_pipe_tag_t stage1_q;
   io_pipe_tag_t stage2_q;
   logic         rsp_valid_q;
   iorsp_packet_t rsp_q;

   rr_arbiter #(
      .NUM_REQUESTERS(NUM_REQUESTERS)
   ) u_rr_arbiter (
      .clk       (clk),
      .reset_n   (reset_n),
      .request   (ior_request_valid),
      .update_lru(|ior_request_valid),
      .grant     (grant)
   );

   assign ia_ready  = grant;
   assign has_grant = |grant;

   // Grant is one-hot, so OR-ing the selected entries yields a plain mux.
   always_comb begin
      grant_core = '0;
      grant_req  = '0;
      for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
         if (grant[i]) begin
            grant_core = core_id_t'(i);
            grant_req  = ior_request[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_en_q   <= 1'b0;
         read_en_q    <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
         stage1_q     <= '0;
         stage2_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_q        <= '0;
      end else begin
         write_en_q          <= has_grant & grant_req.store;
         read_en_q           <= has_grant & ~grant_req.store;
         if (has_grant) begin
            address_q    <= grant_req.address;
            write_data_q <= grant_req.value;
         end
         stage1_q.valid      <= has_grant;
         stage1_q.store      <= grant_req.store;
         stage1_q.core       <= grant_core;
         stage1_q.thread_idx <= grant_req.thread_idx;
         stage2_q            <= stage1_q;
         rsp_valid_q         <= stage2_q.valid;
         rsp_q.core          <= stage2_q.core;
         rsp_q.thread_idx    <= stage2_q.thread_idx;
         // Stores are acknowledged with a zero read value.
         rsp_q.read_value    <= (stage2_q.valid && !stage2_q.store) ? io_bus.read_data : '0;
      end
   end

   assign io_bus.write_en   = write_en_q;
   assign io_bus.read_en    = read_en_q;
   assign io_bus.address    = address_q;
   assign io_bus.write_data = write_data_q;

   assign ia_response_valid = rsp_valid_q;
   assign ia_response       = rsp_q;
endmodule

// File: tb/tb_io_request_arbiter.sv
// Directed bench for io_request_arbiter: grant table, bus/response scoreboard, reset corner.
module tb_io_request_arbiter;
   import io_request_arbiter_pkg::*;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] store;
      logic [3:0] exp_ready;
   } vec_t;

   typedef struct {
      int         due;
      logic       we;
      logic       re;
      scalar_t    addr;
      scalar_t    wdata;
   } bus_exp_t;

   typedef struct {
      int                due;
      core_id_t          core;
      local_thread_idx_t thread_idx;
      scalar_t           value;
   } rsp_exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    ior_request_valid = '0;
   ioreq_packet_t ior_request [4];
   logic [3:0]    ia_ready;
   logic          ia_response_valid;
   iorsp_packet_t ia_response;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic mon_en = 1'b0;

   bus_exp_t bus_q[$];
   rsp_exp_t rsp_q[$];
   vec_t     vecs[17];

   io_bus_interface bus_if();

   io_request_arbiter #(
      .NUM_REQUESTERS(4)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .ior_request_valid(ior_request_valid),
      .ior_request      (ior_request),
      .ia_ready         (ia_ready),
      .ia_response_valid(ia_response_valid),
      .ia_response      (ia_response),
      .io_bus           (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic scalar_t slave_val(input scalar_t addr);
      case (addr)
         32'h104: slave_val = 32'hDEAD_BEEF;
         32'h010: slave_val = 32'd1;
         32'h014: slave_val = 32'd2;
         32'h018: slave_val = 32'd3;
         default: slave_val = addr ^ 32'h5A5A_0000;
      endcase
   endfunction

   // Slave returns read data in the cycle after read_en.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus_if.read_data <= '0;
      else bus_if.read_data <= bus_if.read_en ? slave_val(bus_if.address) : 32'h0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus_q.size() > 0 && bus_q[0].due == cyc) begin
            bus_exp_t e;
            e = bus_q.pop_front();
            check("bus_write_en", 64'(bus_if.write_en), 64'(e.we));
            check("bus_read_en", 64'(bus_if.read_en), 64'(e.re));
            check("bus_address", 64'(bus_if.address), 64'(e.addr));
            if (e.we) check("bus_write_data", 64'(bus_if.write_data), 64'(e.wdata));
         end else begin
            check("bus_idle", 64'({bus_if.write_en, bus_if.read_en}), 64'd0);
         end
         if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            rsp_exp_t r;
            r = rsp_q.pop_front();
            check("rsp_valid", 64'(ia_response_valid), 64'd1);
            check("rsp_core", 64'(ia_response.core), 64'(r.core));
            check("rsp_thread", 64'(ia_response.thread_idx), 64'(r.thread_idx));
            check("rsp_value", 64'(ia_response.read_value), 64'(r.value));
         end else begin
            check("rsp_idle", 64'(ia_response_valid), 64'd0);
         end
      end
   end

   // Drive one cycle of requests, queue expectations derived from exp_rdy, check the grant.
   task automatic apply(input logic [3:0] v, input logic [3:0] exp_rdy);
      int g;
      ior_request_valid = v;
      g = -1;
      for (int p = 0; p < 4; p++) if (exp_rdy[p]) g = p;
      if (g >= 0) begin
         bus_q.push_back('{due: cyc + 1, we: ior_request[g].store, re: !ior_request[g].store,
                           addr: ior_request[g].address, wdata: ior_request[g].value});
         rsp_q.push_back('{due: cyc + 3, core: core_id_t'(g),
                           thread_idx: ior_request[g].thread_idx,
                           value: ior_request[g].store ? 32'h0 :
                                  slave_val(ior_request[g].address)});
      end
      @(negedge clk);
      check("ia_ready", 64'(ia_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      ior_request_valid = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int p = 0; p < 4; p++) ior_request[p] = '0;
      // Pointer sits at 2 on entry; first vector steers it back to 0.
      vecs[0]  = '{4'b1000, 4'b1000, 4'b1000};
      vecs[1]  = '{4'b1111, 4'b0101, 4'b0001};
      vecs[2]  = '{4'b1111, 4'b0101, 4'b0010};
      vecs[3]  = '{4'b1111, 4'b0101, 4'b0100};
      vecs[4]  = '{4'b1111, 4'b0101, 4'b1000};
      vecs[5]  = '{4'b1111, 4'b1010, 4'b0001};
      vecs[6]  = '{4'b1111, 4'b1010, 4'b0010};
      vecs[7]  = '{4'b1111, 4'b1010, 4'b0100};
      vecs[8]  = '{4'b1111, 4'b1010, 4'b1000};
      vecs[9]  = '{4'b0000, 4'b0000, 4'b0000};
      vecs[10] = '{4'b1000, 4'b0000, 4'b1000};
      vecs[11] = '{4'b1001, 4'b0001, 4'b0001};
      vecs[12] = '{4'b1001, 4'b0000, 4'b1000};
      vecs[13] = '{4'b0110, 4'b0100, 4'b0010};
      vecs[14] = '{4'b0011, 4'b0011, 4'b0001};
      vecs[15] = '{4'b0100, 4'b0100, 4'b0100};
      vecs[16] = '{4'b0010, 4'b0000, 4'b0010};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(ia_response_valid), 64'd0);
      check("rst_rsp", 64'(ia_response), 64'd0);
      check("rst_write_en", 64'(bus_if.write_en), 64'd0);
      check("rst_read_en", 64'(bus_if.read_en), 64'd0);
      check("rst_address", 64'(bus_if.address), 64'd0);
      check("rst_write_data", 64'(bus_if.write_data), 64'd0);
      check("rst_ready", 64'(ia_ready), 64'd0);
      reset_n = 1'b1;
      mon_en  = 1'b1;
      idle(1);

      // Single read: port 2, thread 1, addr 0x104 -> 0xDEADBEEF
      ior_request[2] = '{store: 1'b0, thread_idx: 2'd1, address: 32'h104, value: 32'h0};
      apply(4'b0100, 4'b0100);
      idle(4);

      // Single write: port 0, addr 0x20, value 0x55 -> ack with 0
      ior_request[0] = '{store: 1'b1, thread_idx: 2'd0, address: 32'h20, value: 32'h55};
      apply(4'b0001, 4'b0001);
      idle(4);

      // Port 1 back-to-back reads -> 1, 2, 3
      ior_request[1] = '{store: 1'b0, thread_idx: 2'd3, address: 32'h10, value: 32'h0};
      apply(4'b0010, 4'b0010);
      ior_request[1] = '{store: 1'b0, thread_idx: 2'd3, address: 32'h14, value: 32'h0};
      apply(4'b0010, 4'b0010);
      ior_request[1] = '{store: 1'b0, thread_idx: 2'd3, address: 32'h18, value: 32'h0};
      apply(4'b0010, 4'b0010);
      idle(4);

      // Grant table: rotation, wrap, sparse patterns
      for (int k = 0; k < 17; k++) begin
         for (int p = 0; p < 4; p++) begin
            ior_request[p] = '{store: vecs[k].store[p], thread_idx: 2'(p + k),
                               address: 32'h100 + 32'(p * 64 + k * 4),
                               value: 32'hA000_0000 | 32'(k * 16 + p)};
         end
         apply(vecs[k].valid, vecs[k].exp_ready);
      end
      idle(4);

      // Reset in the issue cycle of a read: no response, pointer back to 0
      ior_request[1] = '{store: 1'b0, thread_idx: 2'd2, address: 32'h30, value: 32'h0};
      ior_request_valid = 4'b0010;
      @(negedge clk);
      check("pre_rst_ready", 64'(ia_ready), 64'b0010);
      @(posedge clk);
      #1;
      ior_request_valid = '0;
      check("pre_rst_read_en", 64'(bus_if.read_en), 64'd1);
      reset_n = 1'b0;
      #1;
      check("rst_drop_read_en", 64'(bus_if.read_en), 64'd0);
      idle(2);
      reset_n = 1'b1;
      idle(1);
      ior_request[1] = '{store: 1'b0, thread_idx: 2'd0, address: 32'h40, value: 32'h0};
      ior_request[3] = '{store: 1'b1, thread_idx: 2'd1, address: 32'h44, value: 32'h9};
      apply(4'b1010, 4'b0010);
      idle(6);

      check("queues_drained", 64'(bus_q.size() + rsp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
